// File: rtl/fft_seq_pkg.sv
// Shared constants and FSM state encoding for the FFT frame sequencer.
package fft_seq_pkg;

    localparam int FFT_N  = 16;
    localparam int FFT_DW = 16;
    localparam int FFT_RW = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fft_pingpong_buf.sv
// Ping-pong sample buffer: fills one bank from the FIR stream while the other
// bank is presented to the FFT datapath. The accept decision comes from the FSM.
module fft_pingpong_buf
    import fft_seq_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_fir_valid,
    input  logic [DW-1:0]   i_fir_d,
    input  logic            i_accept,
    output logic            o_frame_done,
    output logic [N*DW-1:0] o_fft_x
);

    localparam int AW = $clog2(N);

    logic [DW-1:0] r_bank [2][N];
    logic [AW-1:0] r_wcnt;
    logic          r_wbank;
    logic          r_rbank;

    assign o_frame_done = i_fir_valid && (r_wcnt == AW'(N - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    r_bank[b][k] <= '0;
                end
            end
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
        end else begin
            if (i_fir_valid) begin
                r_bank[r_wbank][r_wcnt] <= i_fir_d;
                // N is a power of two, so the counter wraps to 0 after N-1 on its own
                r_wcnt <= r_wcnt + AW'(1);
            end
            // A dropped frame leaves wbank alone so the next frame overwrites it
            if (i_accept) begin
                r_wbank <= ~r_wbank;
                r_rbank <= r_wbank;
            end
        end
    end

    always_comb begin
        o_fft_x = '0;
        for (int k = 0; k < N; k++) begin
            o_fft_x[k*DW +: DW] = r_bank[r_rbank][k];
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller between the FIR stream and the 16-point FFT datapath.
// Optional FFT_SEQ_DROP_CNT_EN adds the saturating drop_cnt output.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW,
    parameter int RW = FFT_RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fir_valid,
    input  logic [DW-1:0]   fir_d,
    output logic            fft_start,
    output logic [N*DW-1:0] fft_x,
    input  logic            fft_done,
    input  logic [N*RW-1:0] fft_res,
    output logic            bin_valid,
    input  logic            bin_ready,
    output logic [3:0]      bin_idx,
    output logic [RW-1:0]   bin_d,
    output logic            bin_last,
    output seq_state_t      dbg_state,
    output logic            frame_drop
`ifdef FFT_SEQ_DROP_CNT_EN
    ,
    output logic [15:0]     drop_cnt
`endif
);

    // Output handshake: a beat transfers on a cycle where bin_valid && bin_ready;
    // bin_idx/bin_d/bin_last hold while bin_valid is high and bin_ready is low.

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [3:0]      r_bin_idx;
    logic [N*RW-1:0] r_res;
    logic            r_fft_start;
    logic            r_frame_drop;
    logic            w_frame_done;
    logic            w_last_hs;
    logic            w_accept;
    logic            w_drop;

    fft_pingpong_buf #(.N(N), .DW(DW)) u_buf (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fir_valid  (fir_valid),
        .i_fir_d      (fir_d),
        .i_accept     (w_accept),
        .o_frame_done (w_frame_done),
        .o_fft_x      (fft_x)
    );

    assign w_last_hs = (r_state == S_OUT) && bin_ready && (r_bin_idx == 4'(N - 1));
    assign w_accept  = w_frame_done && ((r_state == S_IDLE) || w_last_hs);
    assign w_drop    = w_frame_done && !w_accept;

    always_comb begin
        w_state_nxt = r_state;
        bin_valid   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (fft_done) w_state_nxt = S_OUT;
            S_OUT: begin
                bin_valid = 1'b1;
                if (w_last_hs) w_state_nxt = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bin_idx    <= '0;
            r_res        <= '0;
            r_fft_start  <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fft_start  <= w_accept;
            r_frame_drop <= w_drop;
            if ((r_state == S_RUN) && fft_done) begin
                r_res     <= fft_res;
                r_bin_idx <= '0;
            end else if (w_last_hs) begin
                r_bin_idx <= '0;
            end else if ((r_state == S_OUT) && bin_ready) begin
                r_bin_idx <= r_bin_idx + 4'd1;
            end
        end
    end

    assign fft_start  = r_fft_start;
    assign frame_drop = r_frame_drop;
    assign bin_idx    = r_bin_idx;
    assign bin_d      = r_res[r_bin_idx*RW +: RW];
    assign bin_last   = (r_bin_idx == 4'(N - 1));
    assign dbg_state  = r_state;

`ifdef FFT_SEQ_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
